// File: rtl/controle_ciclo.sv
// Wash-cycle sequencer: Moore FSM over fill/wash/drain/rinse/spin with per-step
// timers, pause on outage or open lid, and step restore from the protection register.
module controle_ciclo #(
   parameter int T_LAVAR      = 20,
   parameter int T_ENXAGUE    = 10,
   parameter int T_DRENO      = 8,
   parameter int T_CENTRIF    = 12,
   parameter int T_ENCHER_MAX = 30
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       energia,
   input  logic       inicio,
   input  logic       tampa_aberta,
   input  logic       nivel_cheio,
   input  logic [3:0] estado_salvo,
   output logic [3:0] estado,
   output logic       valvula,
   output logic       motor,
   output logic       bomba,
   output logic       trava_tampa,
   output logic       pausado,
   output logic       fim,
   output logic       erro
);

   typedef enum logic [3:0] {
      REPOUSO     = 4'd0,
      ENCHER      = 4'd1,
      LAVAR       = 4'd2,
      DRENAR1     = 4'd3,
      ENCHER2     = 4'd4,
      ENXAGUAR    = 4'd5,
      DRENAR2     = 4'd6,
      CENTRIFUGAR = 4'd7,
      FIM         = 4'd8,
      ERRO        = 4'd15
   } passo_t;

   localparam logic [15:0] LIM_LAVAR    = 16'(T_LAVAR - 1);
   localparam logic [15:0] LIM_ENXAGUE  = 16'(T_ENXAGUE - 1);
   localparam logic [15:0] LIM_DRENO    = 16'(T_DRENO - 1);
   localparam logic [15:0] LIM_CENTRIF  = 16'(T_CENTRIF - 1);
   localparam logic [15:0] LIM_ENCHER   = 16'(T_ENCHER_MAX - 1);

   passo_t      passo, passo_nx;
   logic [15:0] timer;
   logic        energia_r;
   logic        pausado_r;
   logic        pausa_tampa_r;
   logic        recarga;
   logic        limpa_timer;

   function automatic logic ativo(input logic [3:0] p);
      return (p >= 4'd1) && (p <= 4'd7);
   endfunction

   // Power-return reload wins over every normal transition; ERRO only leaves on reset.
   always_comb begin
      passo_nx = passo;
      recarga  = energia && !energia_r && (passo != ERRO);
      if (recarga) begin
         passo_nx = ativo(estado_salvo) ? passo_t'(estado_salvo) : REPOUSO;
      end else if (!pausado_r) begin
         case (passo)
            REPOUSO:     if (inicio && !tampa_aberta && energia) passo_nx = ENCHER;
            ENCHER:      if (nivel_cheio) passo_nx = LAVAR;
                         else if (timer == LIM_ENCHER) passo_nx = ERRO;
            LAVAR:       if (timer == LIM_LAVAR) passo_nx = DRENAR1;
            DRENAR1:     if (timer == LIM_DRENO) passo_nx = ENCHER2;
            ENCHER2:     if (nivel_cheio) passo_nx = ENXAGUAR;
                         else if (timer == LIM_ENCHER) passo_nx = ERRO;
            ENXAGUAR:    if (timer == LIM_ENXAGUE) passo_nx = DRENAR2;
            DRENAR2:     if (timer == LIM_DRENO) passo_nx = CENTRIFUGAR;
            CENTRIFUGAR: if (timer == LIM_CENTRIF) passo_nx = FIM;
            FIM:         if (tampa_aberta) passo_nx = REPOUSO;
            default:     passo_nx = passo;
         endcase
      end
      limpa_timer = recarga || (passo_nx != passo);
   end

   // Pause flags are qualified by the step being entered, so they never linger in FIM/REPOUSO.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         passo         <= REPOUSO;
         timer         <= '0;
         energia_r     <= 1'b0;
         pausado_r     <= 1'b0;
         pausa_tampa_r <= 1'b0;
      end else begin
         passo         <= passo_nx;
         energia_r     <= energia;
         pausado_r     <= ativo(passo_nx) && (!energia || tampa_aberta);
         pausa_tampa_r <= ativo(passo_nx) && tampa_aberta;
         if (limpa_timer)
            timer <= '0;
         else if (ativo(passo) && !pausado_r)
            timer <= timer + 16'd1;
      end
   end

   assign estado      = passo;
   assign valvula     = !pausado_r && (passo == ENCHER || passo == ENCHER2);
   assign motor       = !pausado_r && (passo == LAVAR || passo == ENXAGUAR || passo == CENTRIFUGAR);
   assign bomba       = !pausado_r && (passo == DRENAR1 || passo == DRENAR2 || passo == CENTRIFUGAR);
   assign trava_tampa = ativo(passo) && !pausa_tampa_r;
   assign pausado     = pausado_r;
   assign fim         = (passo == FIM);
   assign erro        = (passo == ERRO);

endmodule

// File: tb/tb_controle_ciclo.sv
// Bench for controle_ciclo: directed wash scenarios plus random stimulus, every
// cycle compared against a step/elapsed-time reference model.
module tb_controle_ciclo;

   localparam int T_LAVAR      = 20;
   localparam int T_ENXAGUE    = 10;
   localparam int T_DRENO      = 8;
   localparam int T_CENTRIF    = 12;
   localparam int T_ENCHER_MAX = 30;

   logic       clk = 1'b0;
   logic       reset, energia, inicio, tampa_aberta, nivel_cheio;
   logic [3:0] estado_salvo;
   logic [3:0] estado;
   logic       valvula, motor, bomba, trava_tampa, pausado, fim, erro;

   int n_cmp = 0;
   int n_err = 0;
   int cnt;

   // reference model: current step, elapsed unpaused time, pause causes
   int m_step, m_tmr;
   bit m_en_r, m_pau, m_lidp;

   controle_ciclo #(
      .T_LAVAR(T_LAVAR), .T_ENXAGUE(T_ENXAGUE), .T_DRENO(T_DRENO),
      .T_CENTRIF(T_CENTRIF), .T_ENCHER_MAX(T_ENCHER_MAX)
   ) dut (
      .clk(clk), .reset(reset), .energia(energia), .inicio(inicio),
      .tampa_aberta(tampa_aberta), .nivel_cheio(nivel_cheio),
      .estado_salvo(estado_salvo), .estado(estado), .valvula(valvula),
      .motor(motor), .bomba(bomba), .trava_tampa(trava_tampa),
      .pausado(pausado), .fim(fim), .erro(erro)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit act(input int s);
      return s >= 1 && s <= 7;
   endfunction

   function automatic int dur(input int s);
      case (s)
         2:       return T_LAVAR;
         3, 6:    return T_DRENO;
         5:       return T_ENXAGUE;
         7:       return T_CENTRIF;
         default: return 0;
      endcase
   endfunction

   task automatic model_reset();
      m_step = 0; m_tmr = 0; m_en_r = 0; m_pau = 0; m_lidp = 0;
   endtask

   task automatic model_update();
      int  nx;
      int  sv;
      bit  reload;
      if (reset) begin
         model_reset();
         return;
      end
      sv     = int'(estado_salvo);
      reload = energia && !m_en_r && m_step != 15;
      nx     = m_step;
      if (reload) begin
         nx = (sv >= 1 && sv <= 7) ? sv : 0;
      end else if (!m_pau) begin
         if (m_step == 0) begin
            if (inicio && !tampa_aberta && energia) nx = 1;
         end else if (m_step == 1 || m_step == 4) begin
            if (nivel_cheio) nx = m_step + 1;
            else if (m_tmr == T_ENCHER_MAX - 1) nx = 15;
         end else if (dur(m_step) > 0) begin
            if (m_tmr == dur(m_step) - 1) nx = m_step + 1;
         end else if (m_step == 8) begin
            if (tampa_aberta) nx = 0;
         end
      end
      if (reload || nx != m_step) m_tmr = 0;
      else if (act(m_step) && !m_pau) m_tmr++;
      m_pau  = act(nx) && (!energia || tampa_aberta);
      m_lidp = act(nx) && tampa_aberta;
      m_en_r = energia;
      m_step = nx;
   endtask

   task automatic compare();
      check("estado", 32'(estado), 32'(m_step));
      check("valvula", 32'(valvula), 32'(!m_pau && (m_step == 1 || m_step == 4)));
      check("motor", 32'(motor), 32'(!m_pau && (m_step == 2 || m_step == 5 || m_step == 7)));
      check("bomba", 32'(bomba), 32'(!m_pau && (m_step == 3 || m_step == 6 || m_step == 7)));
      check("trava_tampa", 32'(trava_tampa), 32'(act(m_step) && !m_lidp));
      check("pausado", 32'(pausado), 32'(m_pau));
      check("fim", 32'(fim), 32'(m_step == 8));
      check("erro", 32'(erro), 32'(m_step == 15));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_update();
      #1;
      compare();
   endtask

   // counts edges taken while in step s and not paused
   task automatic tick_count(input int s);
      if (int'(estado) == s && !pausado) cnt++;
      cycle();
   endtask

   task automatic run_while(input int s, input int budget);
      for (int i = 0; i < budget; i++) begin
         tick_count(s);
         if (int'(estado) != s) break;
      end
   endtask

   task automatic do_reset();
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      compare();
      cycle();
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic defaults();
      energia = 1'b1; inicio = 1'b0; tampa_aberta = 1'b0;
      nivel_cheio = 1'b0; estado_salvo = 4'd0;
   endtask

   task automatic start_and_fill();
      repeat (2) cycle();
      inicio = 1'b1;
      cycle();
      inicio = 1'b0;
      check("start_estado", 32'(estado), 32'd1);
      repeat (4) cycle();
      nivel_cheio = 1'b1;
      cycle();
      nivel_cheio = 1'b0;
   endtask

   task automatic refill();
      repeat (4) cycle();
      nivel_cheio = 1'b1;
      cycle();
      nivel_cheio = 1'b0;
   endtask

   initial begin
      defaults();
      reset = 1'b1;
      model_reset();
      #3;
      compare();
      check("reset_estado", 32'(estado), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // full cycle with measured step durations
      start_and_fill();
      check("full_lavar_entry", 32'(estado), 32'd2);
      cnt = 0; run_while(2, 100); check("dur_lavar", 32'(cnt), 32'(T_LAVAR));
      cnt = 0; run_while(3, 100); check("dur_drenar1", 32'(cnt), 32'(T_DRENO));
      refill();
      check("full_enxaguar_entry", 32'(estado), 32'd5);
      cnt = 0; run_while(5, 100); check("dur_enxaguar", 32'(cnt), 32'(T_ENXAGUE));
      cnt = 0; run_while(6, 100); check("dur_drenar2", 32'(cnt), 32'(T_DRENO));
      cnt = 0; run_while(7, 100); check("dur_centrif", 32'(cnt), 32'(T_CENTRIF));
      check("full_fim", 32'(fim), 32'd1);
      tampa_aberta = 1'b1;
      cycle();
      tampa_aberta = 1'b0;
      check("fim_to_repouso", 32'(estado), 32'd0);

      // fill watchdog
      repeat (2) cycle();
      inicio = 1'b1;
      cycle();
      inicio = 1'b0;
      cnt = 0; run_while(1, 100);
      check("watchdog_cycles", 32'(cnt), 32'(T_ENCHER_MAX));
      check("watchdog_erro", 32'(erro), 32'd1);
      repeat (5) begin
         inicio = 1'($urandom);
         tampa_aberta = 1'($urandom);
         cycle();
         check("erro_valvula_off", 32'(valvula), 32'd0);
         check("erro_held", 32'(estado), 32'd15);
      end
      defaults();
      do_reset();

      // lid pause during LAVAR, then outage during ENXAGUAR
      start_and_fill();
      cnt = 0;
      repeat (5) tick_count(2);
      tampa_aberta = 1'b1;
      repeat (7) begin
         tick_count(2);
         check("lid_pausado", 32'(pausado), 32'd1);
         check("lid_motor", 32'(motor), 32'd0);
         check("lid_trava", 32'(trava_tampa), 32'd0);
      end
      tampa_aberta = 1'b0;
      run_while(2, 100);
      check("lid_lavar_total", 32'(cnt), 32'(T_LAVAR));
      run_while(3, 100);
      refill();
      repeat (6) cycle();
      energia = 1'b0;
      estado_salvo = 4'd5;
      repeat (10) begin
         cycle();
         check("out_estado", 32'(estado), 32'd5);
         check("out_motor", 32'(motor), 32'd0);
         check("out_trava", 32'(trava_tampa), 32'd1);
      end
      energia = 1'b1;
      cycle();
      check("restore_estado", 32'(estado), 32'd5);
      cnt = 0; run_while(5, 100);
      check("restore_enxaguar", 32'(cnt), 32'(T_ENXAGUE));
      defaults();
      do_reset();

      // invalid restore from DRENAR1
      start_and_fill();
      run_while(2, 100);
      repeat (3) cycle();
      energia = 1'b0;
      estado_salvo = 4'd3;
      repeat (5) cycle();
      estado_salvo = 4'd9;
      energia = 1'b1;
      cycle();
      check("inv_estado", 32'(estado), 32'd0);
      check("inv_act", 32'({valvula, motor, bomba}), 32'd0);
      estado_salvo = 4'd0;
      repeat (3) cycle();

      // async reset mid-CENTRIFUGAR
      start_and_fill();
      run_while(2, 100);
      run_while(3, 100);
      refill();
      run_while(5, 100);
      run_while(6, 100);
      repeat (4) cycle();
      check("pre_reset_estado", 32'(estado), 32'd7);
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      check("arst_estado", 32'(estado), 32'd0);
      check("arst_act", 32'({motor, bomba, trava_tampa}), 32'd0);
      cycle();
      @(negedge clk);
      reset = 1'b0;

      // random phase
      for (int i = 0; i < 3000; i++) begin
         energia      = ($urandom_range(99) < 95);
         tampa_aberta = ($urandom_range(99) < 8);
         inicio       = ($urandom_range(99) < 25);
         nivel_cheio  = ($urandom_range(99) < 12);
         estado_salvo = ($urandom_range(3) == 0) ? 4'($urandom) : 4'(m_step);
         if ($urandom_range(999) < 3) do_reset();
         else cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
